// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: ALU op codes, the registered ID->EX payload, datapath widths.
// Latency: none (types and a pure helper function only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_EQ   = 4'b1001,
    ALU_NE   = 4'b1010,
    ALU_GE   = 4'b1011,
    ALU_GEU  = 4'b1100,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Decoded instruction as held in the ID/EX register.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd_addr;
    logic [3:0]        alu_contrl;
    logic              diff;
    logic              use_imm;
    logic              use_pc;
    logic              is_load;
    logic              reg_write;
  } id_ex_t;

  // A producer result applies to a source only when live and not targeting x0.
  function automatic logic fwd_hit(input logic vld, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src);
    return vld && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side, forwarding, EX-side and perf signals of the ID/EX operand stage.
// Latency: none (wiring only).
// Backpressure: id_ready/ex_ready valid-ready pairs; slave = the stage, master = its environment.
interface id_ex_operand_stage_if #(parameter int PERF_W = 32);
  import riscv_pkg::*;

  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rd_addr;
  logic [3:0]        id_alu_contrl;
  logic              id_diff;
  logic              id_use_imm;
  logic              id_use_pc;
  logic              id_is_load;
  logic              id_reg_write;
  logic              mem_fwd_valid;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [XLEN-1:0]   mem_fwd_data;
  logic              wb_fwd_valid;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [XLEN-1:0]   wb_fwd_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_in1;
  logic [XLEN-1:0]   ex_in2;
  logic [3:0]        ex_alu_contrl;
  logic              ex_diff;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_is_load;
  logic              ex_reg_write;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_bubble_cnt;

  modport slave (
    input  flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_alu_contrl, id_diff, id_use_imm, id_use_pc,
           id_is_load, id_reg_write, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
    output id_ready, ex_valid, ex_in1, ex_in2, ex_alu_contrl, ex_diff, ex_store_data,
           ex_pc, ex_rd_addr, ex_is_load, ex_reg_write, perf_stall_cnt, perf_bubble_cnt
  );

  modport master (
    output flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_alu_contrl, id_diff, id_use_imm, id_use_pc,
           id_is_load, id_reg_write, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
    input  id_ready, ex_valid, ex_in1, ex_in2, ex_alu_contrl, ex_diff, ex_store_data,
           ex_pc, ex_rd_addr, ex_is_load, ex_reg_write, perf_stall_cnt, perf_bubble_cnt
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source operand bypass: x0 -> 0, else MEM result, else WB result, else registered value.
// Latency: combinational.
// Backpressure: none; wb_only tells the holder that WB is the winning producer.
// Ports: addr/reg_data = source index and registered value; mem_*/wb_* = producer buses;
//        value = forwarded operand; wb_only = WB matches and MEM does not.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   value,
  output logic              wb_only
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = fwd_hit(mem_valid, mem_rd, addr);
  assign wb_hit  = fwd_hit(wb_valid, wb_rd, addr);
  assign wb_only = wb_hit && !mem_hit;

  always_comb begin
    value = reg_data;
    if (addr == '0)   value = '0;
    else if (mem_hit) value = mem_data;
    else if (wb_hit)  value = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register + ALU operand select with MEM/WB forwarding and one-bubble load-use stall.
// Latency: 1 cycle ID->EX; a load-use hazard costs exactly one bubble.
// Backpressure: id_ready = !ex_valid | ex_ready, minus hazard; ex_ready=0 holds EX (WB still refreshes it).
// Ports: clk, rst_n (sync, active-low); bus = id_ex_operand_stage_if.slave (ID, MEM/WB fwd, EX, perf).
// Option: ID_EX_PERF_EN enables wrapping stall/bubble counters; otherwise perf outputs are 0.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  id_ex_operand_stage_if.slave bus
);

  id_ex_t          ex_q;
  id_ex_t          id_pkt;
  logic            ex_valid_q;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            rs1_wb_only;
  logic            rs2_wb_only;

  // Both sources compared even if the operand ends up unused: cheaper than decoding use_imm/use_pc here.
  assign hazard = ex_valid_q && ex_q.is_load && (ex_q.rd_addr != '0) && bus.id_valid &&
                  ((bus.id_rs1_addr == ex_q.rd_addr) || (bus.id_rs2_addr == ex_q.rd_addr));

  assign bus.id_ready = rst_n && (!ex_valid_q || bus.ex_ready) && !hazard;
  assign accept       = bus.id_valid && bus.id_ready;

  // The register file is read before this cycle's WB write lands, so WB is bypassed at capture.
  always_comb begin
    id_pkt.pc         = bus.id_pc;
    id_pkt.rs1_addr   = bus.id_rs1_addr;
    id_pkt.rs2_addr   = bus.id_rs2_addr;
    id_pkt.rs1_data   = fwd_hit(bus.wb_fwd_valid, bus.wb_fwd_rd, bus.id_rs1_addr) ?
                        bus.wb_fwd_data : bus.id_rs1_data;
    id_pkt.rs2_data   = fwd_hit(bus.wb_fwd_valid, bus.wb_fwd_rd, bus.id_rs2_addr) ?
                        bus.wb_fwd_data : bus.id_rs2_data;
    id_pkt.imm        = bus.id_imm;
    id_pkt.rd_addr    = bus.id_rd_addr;
    id_pkt.alu_contrl = bus.id_alu_contrl;
    id_pkt.diff       = bus.id_diff;
    id_pkt.use_imm    = bus.id_use_imm;
    id_pkt.use_pc     = bus.id_use_pc;
    id_pkt.is_load    = bus.id_is_load;
    id_pkt.reg_write  = bus.id_reg_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_q       <= id_pkt;
    end else if (bus.ex_ready) begin
      // Covers the load-use bubble too: EX drains while ID waits.
      ex_valid_q <= 1'b0;
    end else if (ex_valid_q) begin
      // WB retires during the freeze; latch its value or it is lost once WB moves on.
      // A MEM match wins the mux and MEM is frozen too, so no capture is needed then.
      if (rs1_wb_only) ex_q.rs1_data <= bus.wb_fwd_data;
      if (rs2_wb_only) ex_q.rs2_data <= bus.wb_fwd_data;
    end
  end

  fwd_mux u_fwd_rs1 (
    .addr      (ex_q.rs1_addr),
    .reg_data  (ex_q.rs1_data),
    .mem_valid (bus.mem_fwd_valid),
    .mem_rd    (bus.mem_fwd_rd),
    .mem_data  (bus.mem_fwd_data),
    .wb_valid  (bus.wb_fwd_valid),
    .wb_rd     (bus.wb_fwd_rd),
    .wb_data   (bus.wb_fwd_data),
    .value     (fwd_rs1),
    .wb_only   (rs1_wb_only)
  );

  fwd_mux u_fwd_rs2 (
    .addr      (ex_q.rs2_addr),
    .reg_data  (ex_q.rs2_data),
    .mem_valid (bus.mem_fwd_valid),
    .mem_rd    (bus.mem_fwd_rd),
    .mem_data  (bus.mem_fwd_data),
    .wb_valid  (bus.wb_fwd_valid),
    .wb_rd     (bus.wb_fwd_rd),
    .wb_data   (bus.wb_fwd_data),
    .value     (fwd_rs2),
    .wb_only   (rs2_wb_only)
  );

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_in1        = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign bus.ex_in2        = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_alu_contrl = ex_q.alu_contrl;
  assign bus.ex_diff       = ex_q.diff;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd_addr    = ex_q.rd_addr;
  assign bus.ex_is_load    = ex_q.is_load;
  assign bus.ex_reg_write  = ex_valid_q && ex_q.reg_write;

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] bubble_cnt_q;

  // A bubble is counted whenever the hazard drains EX, even if a flush lands the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ex_valid_q && !bus.ex_ready) stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (hazard && bus.ex_ready)      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.perf_stall_cnt  = stall_cnt_q;
  assign bus.perf_bubble_cnt = bubble_cnt_q;
`else
  assign bus.perf_stall_cnt  = {PERF_W{1'b0}};
  assign bus.perf_bubble_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: vector table through a scoreboard queue plus
// hand-written reset, forwarding, load-use, hold and flush sequences.
// Inputs change 1 ns after the rising edge; outputs are compared mid-cycle.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.PERF_W(32)) bus ();

  id_ex_operand_stage #(.PERF_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        diff;
    logic        use_imm;
    logic        use_pc;
    logic        rw;
    logic [31:0] exp_in1;
    logic [31:0] exp_in2;
    logic [31:0] exp_store;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        diff;
    logic        rw;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush         = 1'b0;
    bus.id_valid      = 1'b0;
    bus.id_pc         = '0;
    bus.id_rs1_addr   = '0;
    bus.id_rs2_addr   = '0;
    bus.id_rs1_data   = '0;
    bus.id_rs2_data   = '0;
    bus.id_imm        = '0;
    bus.id_rd_addr    = '0;
    bus.id_alu_contrl = '0;
    bus.id_diff       = 1'b0;
    bus.id_use_imm    = 1'b0;
    bus.id_use_pc     = 1'b0;
    bus.id_is_load    = 1'b0;
    bus.id_reg_write  = 1'b0;
    bus.mem_fwd_valid = 1'b0;
    bus.mem_fwd_rd    = '0;
    bus.mem_fwd_data  = '0;
    bus.wb_fwd_valid  = 1'b0;
    bus.wb_fwd_rd     = '0;
    bus.wb_fwd_data   = '0;
    bus.ex_ready      = 1'b1;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1a, input logic [4:0] rs2a,
                          input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [3:0] op, input logic diff,
                          input logic use_imm, input logic use_pc, input logic is_load,
                          input logic rw);
    bus.id_valid      = 1'b1;
    bus.id_pc         = pc;
    bus.id_rs1_addr   = rs1a;
    bus.id_rs2_addr   = rs2a;
    bus.id_rs1_data   = rs1d;
    bus.id_rs2_data   = rs2d;
    bus.id_imm        = imm;
    bus.id_rd_addr    = rd;
    bus.id_alu_contrl = op;
    bus.id_diff       = diff;
    bus.id_use_imm    = use_imm;
    bus.id_use_pc     = use_pc;
    bus.id_is_load    = is_load;
    bus.id_reg_write  = rw;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got=empty queue want=entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.name, " ex_valid"},     32'(bus.ex_valid), 32'd1);
      chk({e.name, " in1"},          bus.ex_in1, e.in1);
      chk({e.name, " in2"},          bus.ex_in2, e.in2);
      chk({e.name, " store"},        bus.ex_store_data, e.store);
      chk({e.name, " pc"},           bus.ex_pc, e.pc);
      chk({e.name, " rd"},           32'(bus.ex_rd_addr), 32'(e.rd));
      chk({e.name, " alu_contrl"},   32'(bus.ex_alu_contrl), 32'(e.op));
      chk({e.name, " diff"},         32'(bus.ex_diff), 32'(e.diff));
      chk({e.name, " reg_write"},    32'(bus.ex_reg_write), 32'(e.rw));
    end
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{"add",   32'h100, 5'd1,  5'd2,  32'd5,        32'd7,      32'h0,
                5'd3,  ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        32'd7};
    vecs[1] = '{"addi",  32'h104, 5'd6,  5'd0,  32'h1234,     32'hFFFF,   32'hFFFF_FFFC,
                5'd5,  ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234,     32'hFFFF_FFFC, 32'h0};
    vecs[2] = '{"auipc", 32'h2000, 5'd0, 5'd0,  32'hAAAA,     32'h0,      32'h5000,
                5'd7,  ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2000,     32'h5000,     32'h0};
    vecs[3] = '{"sub_x0", 32'h108, 5'd0, 5'd9,  32'hDEAD,     32'h33,     32'h0,
                5'd8,  ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h33,       32'h33};
    vecs[4] = '{"sra",   32'h10C, 5'd31, 5'd30, 32'h8000_0000, 32'd31,    32'h0,
                5'd31, ALU_SRA, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd31,      32'd31};
    vecs[5] = '{"store", 32'h110, 5'd11, 5'd10, 32'h400,      32'hCAFE,   32'h10,
                5'd0,  ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400,      32'h10,       32'hCAFE};

    // Reset held two edges while ID offers an instruction.
    idle();
    rst_n = 1'b0;
    drive_id(32'h40, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("reset id_ready pre-edge", 32'(bus.id_ready), 32'd0);
    tick();
    tick();
    #3;
    chk("reset ex_valid",     32'(bus.ex_valid), 32'd0);
    chk("reset id_ready",     32'(bus.id_ready), 32'd0);
    chk("reset ex_in1",       bus.ex_in1, 32'd0);
    chk("reset ex_in2",       bus.ex_in2, 32'd0);
    chk("reset ex_pc",        bus.ex_pc, 32'd0);
    chk("reset ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("reset stall_cnt",    bus.perf_stall_cnt, 32'd0);
    chk("reset bubble_cnt",   bus.perf_bubble_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    idle();

    // Table: one instruction at a time, no forwarding traffic.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive_id(vecs[i].pc, vecs[i].rs1a, vecs[i].rs2a, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm,
               vecs[i].rd, vecs[i].op, vecs[i].diff, vecs[i].use_imm, vecs[i].use_pc, 1'b0,
               vecs[i].rw);
      e = '{vecs[i].name, vecs[i].exp_in1, vecs[i].exp_in2, vecs[i].exp_store, vecs[i].pc,
            vecs[i].rd, vecs[i].op, vecs[i].diff, vecs[i].rw};
      sb_q.push_back(e);
      #3;
      chk({vecs[i].name, " id_ready"}, 32'(bus.id_ready), 32'd1);
      tick();
      idle();
      #3;
      pop_check();
    end
    tick();
    #3;
    chk("drain ex_valid", 32'(bus.ex_valid), 32'd0);

    // Forwarding priority, checked combinationally within one held cycle.
    tick();
    drive_id(32'h200, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    bus.ex_ready = 1'b0;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd1; bus.mem_fwd_data = 32'h10;
    bus.wb_fwd_valid  = 1'b1; bus.wb_fwd_rd  = 5'd1; bus.wb_fwd_data  = 32'h20;
    #1 chk("fwd mem over wb in1", bus.ex_in1, 32'h10);
    bus.mem_fwd_valid = 1'b0;
    #1 chk("fwd wb in1", bus.ex_in1, 32'h20);
    bus.wb_fwd_valid = 1'b0;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd2; bus.mem_fwd_data = 32'h77;
    #1 chk("fwd mem in2",    bus.ex_in2, 32'h77);
    chk("fwd mem store",     bus.ex_store_data, 32'h77);
    bus.mem_fwd_valid = 1'b0;
    #1 chk("fwd invalid ignored in2", bus.ex_in2, 32'h2);
    bus.ex_ready = 1'b1;

    // x0 sources never take forwarded data.
    tick();
    drive_id(32'h204, 5'd0, 5'd0, 32'h5, 32'h6, 32'h0, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'h99;
    bus.wb_fwd_valid  = 1'b1; bus.wb_fwd_rd  = 5'd0; bus.wb_fwd_data  = 32'h88;
    #3;
    chk("fwd rd0 in1", bus.ex_in1, 32'h0);
    chk("fwd rd0 in2", bus.ex_in2, 32'h0);

    // WB bypass at capture.
    tick();
    idle();
    drive_id(32'h208, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd1; bus.wb_fwd_data = 32'h55;
    tick();
    idle();
    #3;
    chk("capture bypass in1", bus.ex_in1, 32'h55);
    chk("capture bypass in2", bus.ex_in2, 32'h2);

    // Load-use: LW x4 then ADD x5,x4,x4 -> one bubble, then WB supplies both operands.
    tick();
    drive_id(32'h300, 5'd1, 5'd0, 32'h100, 32'h0, 32'h8, 5'd4, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive_id(32'h304, 5'd4, 5'd4, 32'h111, 32'h111, 32'h0, 5'd5, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("lu load in ex",    32'(bus.ex_is_load), 32'd1);
    chk("lu id_ready low",  32'(bus.id_ready), 32'd0);
    tick();
    #3;
    chk("lu bubble ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu id_ready back",   32'(bus.id_ready), 32'd1);
    tick();
    idle();
    bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd4; bus.wb_fwd_data = 32'hDEAD;
    #3;
    chk("lu ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu in1",      bus.ex_in1, 32'hDEAD);
    chk("lu in2",      bus.ex_in2, 32'hDEAD);
    chk("lu rd",       32'(bus.ex_rd_addr), 32'd5);

    // A load to x0 causes no stall.
    tick();
    idle();
    drive_id(32'h308, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_id(32'h30C, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("lw x0 no hazard", 32'(bus.id_ready), 32'd1);
    tick();
    idle();

    // Hold three cycles; WB writes rs2 during the first and then leaves.
    tick();
    drive_id(32'h400, 5'd1, 5'd2, 32'h9, 32'h1, 32'h0, 5'd6, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = '{"hold", 32'h9, 32'hAB, 32'hAB, 32'h400, 5'd6, ALU_ADD, 1'b0, 1'b1};
    sb_q.push_back(e);
    tick();
    idle();
    bus.ex_ready = 1'b0;
    bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd2; bus.wb_fwd_data = 32'hAB;
    #3;
    chk("hold c1 in2",      bus.ex_in2, 32'hAB);
    chk("hold c1 id_ready", 32'(bus.id_ready), 32'd0);
    tick();
    bus.wb_fwd_valid = 1'b0;
    #3;
    chk("hold c2 in2", bus.ex_in2, 32'hAB);
    tick();
    #3;
    chk("hold c3 ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("hold c3 in2",      bus.ex_in2, 32'hAB);
    bus.ex_ready = 1'b1;
    #1 pop_check();
    tick();
    #3;
    chk("hold drained", 32'(bus.ex_valid), 32'd0);

    // Hold with MEM and WB both matching: MEM wins and nothing is latched.
    tick();
    drive_id(32'h404, 5'd1, 5'd2, 32'h9, 32'h1, 32'h0, 5'd6, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    bus.ex_ready = 1'b0;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd2; bus.mem_fwd_data = 32'h66;
    bus.wb_fwd_valid  = 1'b1; bus.wb_fwd_rd  = 5'd2; bus.wb_fwd_data  = 32'hAB;
    #3;
    chk("hold mem in2", bus.ex_in2, 32'h66);
    tick();
    bus.mem_fwd_valid = 1'b0;
    bus.wb_fwd_valid  = 1'b0;
    #3;
    chk("hold mem no latch in2", bus.ex_in2, 32'h1);
    bus.ex_ready = 1'b1;

    // Flush with ID offering an instruction.
    tick();
    drive_id(32'h500, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive_id(32'h504, 5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 5'd7, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    #3;
    chk("flush id_ready", 32'(bus.id_ready), 32'd1);
    tick();
    idle();
    #3;
    chk("flush ex_valid",     32'(bus.ex_valid), 32'd0);
    chk("flush ex_reg_write", 32'(bus.ex_reg_write), 32'd0);

    // Flush while EX is frozen.
    tick();
    drive_id(32'h508, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    bus.ex_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    idle();
    #3;
    chk("flush held ex_valid", 32'(bus.ex_valid), 32'd0);

`ifdef ID_EX_PERF_EN
    chk("perf bubble count", bus.perf_bubble_cnt, 32'd1);
`else
    chk("perf bubble tied", bus.perf_bubble_cnt, 32'd0);
    chk("perf stall tied",  bus.perf_stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
